// File: rtl/ahb_pkg.sv
// Shared AHB constants, default-slave state encoding and transfer-type helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        S_DATA = 2'b00,
        S_ERR1 = 2'b01,
        S_ERR2 = 2'b10
    } state_e;

    // NONSEQ/SEQ carry a real data phase; IDLE/BUSY do not.
    function automatic logic htrans_active(input logic [1:0] t);
        logic act;
        act = 1'b0;
        case (t)
            HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default: act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR sequencer for unmapped transfers.
// With AHB_MUX_TIMEOUT_EN defined, also forces ERROR after TIMEOUT_CYCLES wait states.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic hready_i,
    input  logic xfer_i,
    input  logic addr_hit_i,
`ifdef AHB_MUX_TIMEOUT_EN
    input  logic dwait_i,
`endif
    output logic active_o,
    output logic hready_o,
    output logic hresp_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e state_q, state_d;
    logic   unmapped_accept;

    assign unmapped_accept = hready_i && xfer_i && !addr_hit_i;

`ifdef AHB_MUX_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout;

    assign timeout = (state_q == S_DATA) && dwait_i
                  && (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive stalled data-phase cycles; any completed beat restarts it.
    always_comb begin
        wcnt_d = wcnt_q;
        if (hready_i || state_q != S_DATA) begin
            wcnt_d = '0;
        end else if (dwait_i) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_o = 1'b0;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        case (state_q)
            S_DATA: begin
                if (timeout || unmapped_accept) begin
                    state_d = S_ERR1;
                end
            end
            S_ERR1: begin
                active_o = 1'b1;
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = S_ERR2;
            end
            S_ERR2: begin
                active_o = 1'b1;
                hresp_o  = HRESP_ERROR;
                state_d  = unmapped_accept ? S_ERR1 : S_DATA;
            end
            default: begin
                state_d = S_DATA;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB response mux: registers the address-phase select and routes slave
// responses in the data phase. Optional wait-state timeout: AHB_MUX_TIMEOUT_EN.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [1:0]            sel,
    input  logic                  addr_hit,
    input  logic [1:0]            htrans,
    input  logic [DATA_WIDTH-1:0] hrdata_1,
    input  logic [DATA_WIDTH-1:0] hrdata_2,
    input  logic [DATA_WIDTH-1:0] hrdata_3,
    input  logic [DATA_WIDTH-1:0] hrdata_4,
    input  logic                  hreadyout_1,
    input  logic                  hreadyout_2,
    input  logic                  hreadyout_3,
    input  logic                  hreadyout_4,
    input  logic                  hresp_1,
    input  logic                  hresp_2,
    input  logic                  hresp_3,
    input  logic                  hresp_4,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    logic [1:0]            dsel_q, dsel_d;
    logic                  dvalid_q, dvalid_d;
    logic                  dhit_q, dhit_d;
    logic                  xfer;
    logic                  routed;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_ready;
    logic                  sel_resp;
    logic                  def_active;
    logic                  def_hready;
    logic                  def_hresp;

    assign xfer   = htrans_active(htrans);
    assign routed = dvalid_q && dhit_q && !def_active;

    always_comb begin
        sel_rdata = hrdata_1;
        sel_ready = hreadyout_1;
        sel_resp  = hresp_1;
        case (dsel_q)
            2'd0: begin sel_rdata = hrdata_1; sel_ready = hreadyout_1; sel_resp = hresp_1; end
            2'd1: begin sel_rdata = hrdata_2; sel_ready = hreadyout_2; sel_resp = hresp_2; end
            2'd2: begin sel_rdata = hrdata_3; sel_ready = hreadyout_3; sel_resp = hresp_3; end
            2'd3: begin sel_rdata = hrdata_4; sel_ready = hreadyout_4; sel_resp = hresp_4; end
            default: ;
        endcase
    end

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (def_active) begin
            hready = def_hready;
            hresp  = def_hresp;
        end else if (routed) begin
            hrdata = sel_rdata;
            hready = sel_ready;
            hresp  = sel_resp;
        end
    end

    // Address phase is captured only on edges that complete the current data phase.
    always_comb begin
        dsel_d   = dsel_q;
        dvalid_d = dvalid_q;
        dhit_d   = dhit_q;
        if (hready) begin
            dsel_d   = sel;
            dvalid_d = xfer;
            dhit_d   = addr_hit;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q   <= 2'b00;
            dvalid_q <= 1'b0;
            dhit_q   <= 1'b0;
        end else begin
            dsel_q   <= dsel_d;
            dvalid_q <= dvalid_d;
            dhit_q   <= dhit_d;
        end
    end

    ahb_default_slave #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_default_slave (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hready_i   (hready),
        .xfer_i     (xfer),
        .addr_hit_i (addr_hit),
`ifdef AHB_MUX_TIMEOUT_EN
        .dwait_i    (dvalid_q && dhit_q && !sel_ready),
`endif
        .active_o   (def_active),
        .hready_o   (def_hready),
        .hresp_o    (def_hresp)
    );

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed self-checking bench for ahb_slave_mux (TIMEOUT_CYCLES=4).
module tb_ahb_slave_mux;

    localparam int unsigned DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [1:0]    sel;
    logic          addr_hit;
    logic [1:0]    htrans;
    logic [DW-1:0] hrdata_1, hrdata_2, hrdata_3, hrdata_4;
    logic          hreadyout_1, hreadyout_2, hreadyout_3, hreadyout_4;
    logic          hresp_1, hresp_2, hresp_3, hresp_4;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    ahb_slave_mux #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .sel         (sel),
        .addr_hit    (addr_hit),
        .htrans      (htrans),
        .hrdata_1    (hrdata_1),
        .hrdata_2    (hrdata_2),
        .hrdata_3    (hrdata_3),
        .hrdata_4    (hrdata_4),
        .hreadyout_1 (hreadyout_1),
        .hreadyout_2 (hreadyout_2),
        .hreadyout_3 (hreadyout_3),
        .hreadyout_4 (hreadyout_4),
        .hresp_1     (hresp_1),
        .hresp_2     (hresp_2),
        .hresp_3     (hresp_3),
        .hresp_4     (hresp_4),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [1:0] s, input logic hit);
        htrans   = t;
        sel      = s;
        addr_hit = hit;
    endtask

    task automatic chk_bus(input string tag, input logic rdy, input logic rsp);
        #1;
        chk({tag, "_hready"}, 32'(hready), 32'(rdy));
        chk({tag, "_hresp"},  32'(hresp),  32'(rsp));
    endtask

    initial begin
        hresetn = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        hrdata_1 = 32'h1111_1111; hrdata_2 = 32'hA5A5_A5A5;
        hrdata_3 = 32'h5A5A_5A5A; hrdata_4 = 32'h4444_4444;
        hreadyout_1 = 1'b0; hreadyout_2 = 1'b1; hreadyout_3 = 1'b1; hreadyout_4 = 1'b1;
        hresp_1 = 1'b1; hresp_2 = 1'b0; hresp_3 = 1'b0; hresp_4 = 1'b0;

        #3;
        chk_bus("reset", 1'b1, 1'b0);
        chk("reset_hrdata", hrdata, 32'h0);
        hreadyout_1 = 1'b1; hresp_1 = 1'b0;
        #8 hresetn = 1'b1;

        // pipelined reads to slaves 2 and 3
        tick(); drive(2'b10, 2'b01, 1'b1); chk_bus("pipe_addr", 1'b1, 1'b0);
        tick(); drive(2'b11, 2'b10, 1'b1); chk_bus("pipe_d1", 1'b1, 1'b0);
        chk("pipe_d1_hrdata", hrdata, 32'hA5A5_A5A5);
        tick(); drive(2'b00, 2'b00, 1'b1); chk_bus("pipe_d2", 1'b1, 1'b0);
        chk("pipe_d2_hrdata", hrdata, 32'h5A5A_5A5A);
        tick(); chk_bus("pipe_idle", 1'b1, 1'b0);
        chk("pipe_idle_hrdata", hrdata, 32'h0);

        // wait states on slave 4; address changes during the stall must be ignored
        tick(); drive(2'b10, 2'b11, 1'b1); #1;
        tick(); drive(2'b10, 2'b00, 1'b1); hreadyout_4 = 1'b0; chk_bus("wait1", 1'b0, 1'b0);
        tick(); drive(2'b11, 2'b01, 1'b0); hreadyout_4 = 1'b0; chk_bus("wait2", 1'b0, 1'b0);
        tick(); drive(2'b00, 2'b00, 1'b1); hreadyout_4 = 1'b1; chk_bus("wait_done", 1'b1, 1'b0);
        chk("wait_done_hrdata", hrdata, 32'h4444_4444);
        tick(); chk_bus("wait_after", 1'b1, 1'b0);

        // unmapped NONSEQ -> two-cycle ERROR
        tick(); drive(2'b10, 2'b00, 1'b0); #1;
        tick(); drive(2'b00, 2'b00, 1'b0); chk_bus("unmap_err1", 1'b0, 1'b1);
        chk("unmap_err1_hrdata", hrdata, 32'h0);
        tick(); chk_bus("unmap_err2", 1'b1, 1'b1);
        tick(); chk_bus("unmap_okay", 1'b1, 1'b0);

        // IDLE to unmapped space is harmless
        tick(); drive(2'b00, 2'b10, 1'b0); #1;
        tick(); chk_bus("idle_unmap", 1'b1, 1'b0);
        tick(); drive(2'b01, 2'b10, 1'b0); #1;
        tick(); drive(2'b00, 2'b00, 1'b1); chk_bus("busy_unmap", 1'b1, 1'b0);

        // unmapped SEQ, then another unmapped accepted in the second ERROR cycle
        tick(); drive(2'b11, 2'b00, 1'b0); #1;
        tick(); drive(2'b10, 2'b00, 1'b1); chk_bus("b2b_err1", 1'b0, 1'b1);
        tick(); drive(2'b10, 2'b01, 1'b0); chk_bus("b2b_err2", 1'b1, 1'b1);
        tick(); drive(2'b00, 2'b00, 1'b1); chk_bus("b2b_err1_again", 1'b0, 1'b1);
        tick(); chk_bus("b2b_err2_again", 1'b1, 1'b1);
        tick(); chk_bus("b2b_okay", 1'b1, 1'b0);

        // slave ERROR passes through unchanged
        tick(); drive(2'b10, 2'b00, 1'b1); #1;
        tick(); drive(2'b00, 2'b00, 1'b1); hreadyout_1 = 1'b0; hresp_1 = 1'b1;
        chk_bus("slv_err1", 1'b0, 1'b1);
        tick(); hreadyout_1 = 1'b1; hresp_1 = 1'b1; chk_bus("slv_err2", 1'b1, 1'b1);
        tick(); hresp_1 = 1'b0; chk_bus("slv_after", 1'b1, 1'b0);

        // async reset during an ERROR sequence discards it
        tick(); drive(2'b10, 2'b00, 1'b0); #1;
        tick(); drive(2'b00, 2'b00, 1'b1); chk_bus("rst_pre", 1'b0, 1'b1);
        #2 hresetn = 1'b0;
        chk_bus("rst_mid", 1'b1, 1'b0);
        #2 hresetn = 1'b1;
        tick(); chk_bus("rst_after", 1'b1, 1'b0);

        // slave 1 held not-ready: timeout build forces ERROR after 4 waits
        tick(); drive(2'b10, 2'b00, 1'b1); #1;
        for (int i = 0; i < 8; i++) begin
            tick(); drive(2'b00, 2'b00, 1'b1); hreadyout_1 = 1'b0;
`ifdef AHB_MUX_TIMEOUT_EN
            chk_bus($sformatf("timeout_c%0d", i), (i >= 5), (i == 4 || i == 5));
`else
            chk_bus($sformatf("stall_c%0d", i), 1'b0, 1'b0);
`endif
        end
        tick(); hreadyout_1 = 1'b1; chk_bus("stall_release", 1'b1, 1'b0);
`ifdef AHB_MUX_TIMEOUT_EN
        chk("stall_release_hrdata", hrdata, 32'h0);
`else
        chk("stall_release_hrdata", hrdata, 32'h1111_1111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mux.md
Name: ahb_slave_mux

Overview:
Response-side counterpart of the AHB address decoder. It registers the slave select at each accepted address phase and routes the selected slave's hrdata/hreadyout/hresp back to the master during the data phase. A built-in default slave returns OKAY for IDLE/BUSY transfers and a two-cycle ERROR for unmapped NONSEQ/SEQ transfers. It sits between the four AHB slaves and the single master.

Parameters:
DATA_WIDTH, 32, width of read data buses.
TIMEOUT_CYCLES, 16, max consecutive wait states before forced ERROR (used only with AHB_MUX_TIMEOUT_EN).

Ports:
hclk  input  1  bus clock, all state on rising edge.
hresetn  input  1  asynchronous active-low reset.
sel  input  2  address-phase slave index from the decoder (00..11 -> slave 1..4).
addr_hit  input  1  address-phase flag: address falls in a mapped region.
htrans  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
hrdata_1..hrdata_4  input  DATA_WIDTH  slave read data.
hreadyout_1..hreadyout_4  input  1  slave ready.
hresp_1..hresp_4  input  1  slave response (0 OKAY, 1 ERROR).
hrdata  output  DATA_WIDTH  muxed read data to master.
hready  output  1  bus ready to master and to all slaves.
hresp  output  1  muxed response to master.

Behaviour:
- Clock hclk; reset hresetn asynchronous, active-low; deassertion takes effect on the next hclk rising edge.
- Reset: dsel=00, dvalid=0, dhit=0, state=S_DATA -> hready=1, hresp=0, hrdata=0.
- Address phase accepted on any rising edge where hready=1: dsel<=sel, dvalid<=htrans[1], dhit<=addr_hit. When hready=0, all registers hold.
- Data-phase output (combinational from registers):
  - dvalid=0: hready=1, hresp=0, hrdata=0 (no wait, OKAY).
  - dvalid=1, dhit=1, state S_DATA: hrdata/hready/hresp = slave[dsel] signals.
  - dvalid=1, dhit=0: default slave responds ERROR; state S_DATA -> S_ERR1 without waiting.
- State machine:
  - S_DATA: normal routing as above.
  - S_ERR1: hready=0, hresp=1, hrdata=0; next state unconditionally S_ERR2.
  - S_ERR2: hready=1, hresp=1, hrdata=0; next address phase is accepted on this edge; next state is S_DATA, or S_ERR1 again if the newly accepted transfer is unmapped NONSEQ/SEQ.
- Entry from S_DATA to S_ERR1 happens on the edge that accepts an unmapped NONSEQ/SEQ. Behaviour is therefore identical whether the previous data phase was zero-wait or the end of a wait sequence.
- Latency: zero added cycles; the mux is purely a data-phase select.
- Back-to-back mapped transfers to different slaves: dsel switches on the edge where hready=1, with no bubble.
- htrans or sel changes while hready=0 are ignored.
- Slave hresp=1 with hreadyout=0 (first ERROR cycle of a slave) passes through unchanged.
- Reset mid-transfer: outputs return to reset values immediately (asynchronously); any pending ERROR sequence is discarded.

Optional Feature:
AHB_MUX_TIMEOUT_EN
- With the macro defined: wcnt counts consecutive S_DATA cycles with dvalid=1, dhit=1 and the selected hreadyout=0; it clears whenever hready=1.
  - When wcnt reaches TIMEOUT_CYCLES-1 and the slave is still not ready, the next state is S_ERR1. The slave's signals are then ignored until S_ERR2 completes.
  - wcnt is $clog2(TIMEOUT_CYCLES+1) bits and resets to 0.
- Without the macro: no counter is present, wait states are unbounded, and the logic above is otherwise identical.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HRESP_OKAY/ERROR constants.
  - State enum {S_DATA, S_ERR1, S_ERR2}.
- One natural sub-module: ahb_default_slave. It holds the S_ERR1/S_ERR2 FSM and the optional timeout counter, and outputs a default hready/hresp plus an active flag for the mux to select.

Test Plan:
1. Reset: hresetn=0 at any time -> hready=1, hresp=0, hrdata=0 within the same cycle.
2. Pipelined reads: NONSEQ sel=01 then SEQ sel=10, both hit; hrdata_2=0xA5A5A5A5 and hrdata_3=0x5A5A5A5A, all slaves ready -> hrdata=0xA5A5A5A5 then 0x5A5A5A5A on consecutive cycles, hresp=0.
3. Wait states: NONSEQ sel=11 with hreadyout_4 low for 2 cycles -> hready=0 for 2 cycles then 1. A sel change during the wait is ignored, and data comes from slave 4.
4. Unmapped: NONSEQ with addr_hit=0 -> next cycle hready=0/hresp=1, following cycle hready=1/hresp=1, then OKAY idle.
5. IDLE with addr_hit=0 -> hready=1, hresp=0, with no ERROR.
6. With AHB_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave 1 is held not-ready -> after 4 wait cycles a two-cycle ERROR is issued. Without the macro, hready stays 0 indefinitely.
